// File: rtl/alu_resp_checker_pkg.sv
// Shared types for the ALU response checker: FSM states, the response
// record stored in the expectation FIFO, and the field-compare helper.
package alu_resp_checker_pkg;

    localparam int RES_W = 8;
    localparam int RSP_W = RES_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } chk_state_t;

    // Packed so that {equal, result} is the 9-bit view used on the capture ports.
    typedef struct packed {
        logic             equal;
        logic [RES_W-1:0] result;
    } alu_rsp_t;

    // True when both Equal and Result agree.
    function automatic logic rsp_match(input alu_rsp_t a, input alu_rsp_t b);
        return (a.equal == b.equal) && (a.result == b.result);
    endfunction

endpackage

// File: rtl/alu_resp_checker_fifo.sv
// Synchronous expectation FIFO. Pointers carry one extra wrap bit so that
// full and empty are distinguished without a separate occupancy counter.
module chk_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    // Guard against overflow/underflow even if the caller misbehaves.
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Pointer update; wrap is handled by the natural roll-over of the extra bit.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    // Storage write; cleared on reset so the head never shows stale data.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/alu_resp_checker.sv
// Response-side scoreboard: queues expected ALU responses from the driver,
// compares the ALU's in-order response stream against the oldest entry and
// keeps saturating pass/fail counts, sticky flags and a first-failure capture.
module alu_resp_checker
    import alu_resp_checker_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             enable,
    input  logic             exp_valid,
    output logic             exp_ready,
    input  logic [RES_W-1:0] exp_result,
    input  logic             exp_equal,
    input  logic             rsp_valid,
    input  logic [RES_W-1:0] rsp_result,
    input  logic             rsp_equal,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err,
    output logic             orphan,
    output logic [RSP_W-1:0] ff_exp,
    output logic [RSP_W-1:0] ff_rsp,
    output logic             done,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam alu_rsp_t         ORPHAN_EXP = {1'b1, {RES_W{1'b1}}};

    chk_state_t       state_q, state_d;
    logic [CNT_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0] fail_q, fail_d;
    logic             err_q, err_d;
    logic             orphan_q, orphan_d;
    alu_rsp_t         ff_exp_q, ff_exp_d;
    alu_rsp_t         ff_rsp_q, ff_rsp_d;
    logic             done_q, done_d;

    logic             clear_s;
    logic             active_s;
    logic             push_s;
    logic             take_s;
    logic             pop_s;
    logic             orphan_hit_s;
    logic             mismatch_s;
    logic             pass_hit_s;
    logic             fail_hit_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    alu_rsp_t         exp_in_s;
    alu_rsp_t         rsp_in_s;
    alu_rsp_t         head_s;

    assign exp_in_s = '{equal: exp_equal, result: exp_result};
    assign rsp_in_s = '{equal: rsp_equal, result: rsp_result};

    // Expectations are only accepted while running; draining refuses new work.
    assign exp_ready    = (state_q == RUN) && !fifo_full_s;
    assign push_s       = exp_valid && exp_ready;
    assign active_s     = (state_q == RUN) || (state_q == DRAIN);
    assign take_s       = rsp_valid && active_s;
    // No same-cycle bypass: a response against an empty FIFO is an orphan
    // even when an expectation is being pushed on the same edge.
    assign pop_s        = take_s && !fifo_empty_s;
    assign orphan_hit_s = take_s && fifo_empty_s;
    assign mismatch_s   = pop_s && !rsp_match(head_s, rsp_in_s);
    assign pass_hit_s   = pop_s && !mismatch_s;
    assign fail_hit_s   = orphan_hit_s || mismatch_s;

    chk_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (RSP_W)
    ) u_fifo (
        .clk   (clk),
        .rstb  (rstb),
        .push  (push_s),
        .pop   (pop_s),
        .din   (exp_in_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .head  (head_s)
    );

    // Run-control FSM; statistics are cleared only when a fresh run starts.
    always_comb begin
        state_d = state_q;
        clear_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = RUN;
                    clear_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = DRAIN;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (enable) begin
                    state_d = RUN;
                end else if (fifo_empty_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Scoreboard statistics: saturating counters, sticky flags, first-failure capture.
    always_comb begin
        pass_d   = pass_q;
        fail_d   = fail_q;
        err_d    = err_q;
        orphan_d = orphan_q;
        ff_exp_d = ff_exp_q;
        ff_rsp_d = ff_rsp_q;
        if (clear_s) begin
            pass_d   = '0;
            fail_d   = '0;
            err_d    = 1'b0;
            orphan_d = 1'b0;
            ff_exp_d = '0;
            ff_rsp_d = '0;
        end else begin
            if (pass_hit_s && (pass_q != CNT_MAX)) begin
                pass_d = pass_q + CNT_ONE;
            end else begin
                pass_d = pass_q;
            end
            if (fail_hit_s) begin
                if (fail_q != CNT_MAX) begin
                    fail_d = fail_q + CNT_ONE;
                end else begin
                    fail_d = fail_q;
                end
                err_d    = 1'b1;
                orphan_d = orphan_q || orphan_hit_s;
                if (!err_q) begin
                    ff_exp_d = orphan_hit_s ? ORPHAN_EXP : head_s;
                    ff_rsp_d = rsp_in_s;
                end else begin
                    ff_exp_d = ff_exp_q;
                    ff_rsp_d = ff_rsp_q;
                end
            end else begin
                fail_d = fail_q;
            end
        end
    end

    // done marks the cycle in which the checker has just returned to IDLE.
    always_comb begin
        done_d = (state_q == DRAIN) && (state_d == IDLE);
    end

    // State and statistics registers.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q  <= IDLE;
            pass_q   <= '0;
            fail_q   <= '0;
            err_q    <= 1'b0;
            orphan_q <= 1'b0;
            ff_exp_q <= '0;
            ff_rsp_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            err_q    <= err_d;
            orphan_q <= orphan_d;
            ff_exp_q <= ff_exp_d;
            ff_rsp_q <= ff_rsp_d;
            done_q   <= done_d;
        end
    end

    assign pass_cnt = pass_q;
    assign fail_cnt = fail_q;
    assign err      = err_q;
    assign orphan   = orphan_q;
    assign ff_exp   = ff_exp_q;
    assign ff_rsp   = ff_rsp_q;
    assign done     = done_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_alu_resp_checker.sv
// Directed bench for alu_resp_checker (DEPTH=4, CNT_W=4 so saturation is reachable).
module tb_alu_resp_checker;

    logic       clk;
    logic       rstb;
    logic       enable;
    logic       exp_valid;
    logic       exp_ready;
    logic [7:0] exp_result;
    logic       exp_equal;
    logic       rsp_valid;
    logic [7:0] rsp_result;
    logic       rsp_equal;
    logic [3:0] pass_cnt;
    logic [3:0] fail_cnt;
    logic       err;
    logic       orphan;
    logic [8:0] ff_exp;
    logic [8:0] ff_rsp;
    logic       done;
    logic       busy;

    int checks;
    int failures;

    alu_resp_checker #(
        .DEPTH (4),
        .CNT_W (4)
    ) dut (
        .clk        (clk),
        .rstb       (rstb),
        .enable     (enable),
        .exp_valid  (exp_valid),
        .exp_ready  (exp_ready),
        .exp_result (exp_result),
        .exp_equal  (exp_equal),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .rsp_equal  (rsp_equal),
        .pass_cnt   (pass_cnt),
        .fail_cnt   (fail_cnt),
        .err        (err),
        .orphan     (orphan),
        .ff_exp     (ff_exp),
        .ff_rsp     (ff_rsp),
        .done       (done),
        .busy       (busy)
    );

    // 100 MHz-style free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Return to IDLE through DRAIN (FIFO must be empty) and start a fresh run.
    task automatic restart();
        enable = 1'b0;
        step();
        step();
        enable = 1'b1;
        step();
    endtask

    task automatic push_one(input logic eq, input logic [7:0] res);
        exp_valid  = 1'b1;
        exp_equal  = eq;
        exp_result = res;
        step();
        exp_valid  = 1'b0;
    endtask

    task automatic rsp_one(input logic eq, input logic [7:0] res);
        rsp_valid  = 1'b1;
        rsp_equal  = eq;
        rsp_result = res;
        step();
        rsp_valid  = 1'b0;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rstb       = 1'b0;
        enable     = 1'b0;
        exp_valid  = 1'b0;
        exp_result = 8'h00;
        exp_equal  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_result = 8'h00;
        rsp_equal  = 1'b0;
        step();
        step();

        // Reset state
        check_eq("rst_exp_ready", {31'd0, exp_ready}, 32'd0);
        check_eq("rst_pass", {28'd0, pass_cnt}, 32'd0);
        check_eq("rst_fail", {28'd0, fail_cnt}, 32'd0);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        check_eq("rst_orphan", {31'd0, orphan}, 32'd0);
        check_eq("rst_ff_exp", {23'd0, ff_exp}, 32'd0);
        check_eq("rst_ff_rsp", {23'd0, ff_rsp}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        rstb = 1'b1;
        step();

        // Basic match
        enable = 1'b1;
        step();
        check_eq("run_busy", {31'd0, busy}, 32'd1);
        check_eq("run_exp_ready", {31'd0, exp_ready}, 32'd1);
        push_one(1'b0, 8'h02);
        step();
        rsp_one(1'b0, 8'h02);
        check_eq("match_pass", {28'd0, pass_cnt}, 32'd1);
        check_eq("match_fail", {28'd0, fail_cnt}, 32'd0);
        check_eq("match_err", {31'd0, err}, 32'd0);

        // Fill to full with exp_valid held high, then one pop frees a slot
        exp_valid = 1'b1;
        exp_equal = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_result = 8'h10 + 8'(i);
            step();
        end
        exp_result = 8'h14;
        check_eq("full_exp_ready", {31'd0, exp_ready}, 32'd0);
        rsp_valid  = 1'b1;
        rsp_equal  = 1'b0;
        rsp_result = 8'h10;
        step();
        rsp_valid = 1'b0;
        check_eq("pop_exp_ready", {31'd0, exp_ready}, 32'd1);
        step();
        exp_valid = 1'b0;
        check_eq("refill_exp_ready", {31'd0, exp_ready}, 32'd0);
        for (int i = 1; i < 5; i++) begin
            rsp_one(1'b0, 8'h10 + 8'(i));
        end
        check_eq("fill_pass", {28'd0, pass_cnt}, 32'd6);
        check_eq("fill_fail", {28'd0, fail_cnt}, 32'd0);

        // Mismatch and first-failure capture
        restart();
        check_eq("clear_pass", {28'd0, pass_cnt}, 32'd0);
        push_one(1'b1, 8'h05);
        push_one(1'b0, 8'h07);
        rsp_one(1'b0, 8'h05);
        rsp_one(1'b0, 8'h07);
        check_eq("mm_fail", {28'd0, fail_cnt}, 32'd1);
        check_eq("mm_pass", {28'd0, pass_cnt}, 32'd1);
        check_eq("mm_err", {31'd0, err}, 32'd1);
        check_eq("mm_orphan", {31'd0, orphan}, 32'd0);
        check_eq("mm_ff_exp", {23'd0, ff_exp}, 32'h105);
        check_eq("mm_ff_rsp", {23'd0, ff_rsp}, 32'h005);
        push_one(1'b0, 8'h09);
        rsp_one(1'b0, 8'h08);
        check_eq("mm2_fail", {28'd0, fail_cnt}, 32'd2);
        check_eq("mm2_ff_exp_held", {23'd0, ff_exp}, 32'h105);
        check_eq("mm2_ff_rsp_held", {23'd0, ff_rsp}, 32'h005);

        // Orphan in RUN
        restart();
        rsp_one(1'b0, 8'h33);
        check_eq("orph_orphan", {31'd0, orphan}, 32'd1);
        check_eq("orph_fail", {28'd0, fail_cnt}, 32'd1);
        check_eq("orph_err", {31'd0, err}, 32'd1);
        check_eq("orph_ff_exp", {23'd0, ff_exp}, 32'h1FF);
        check_eq("orph_ff_rsp", {23'd0, ff_rsp}, 32'h033);

        // Same-cycle push and response on an empty FIFO: orphan, push still enters
        restart();
        exp_valid  = 1'b1;
        exp_equal  = 1'b0;
        exp_result = 8'h44;
        rsp_valid  = 1'b1;
        rsp_equal  = 1'b0;
        rsp_result = 8'h44;
        step();
        exp_valid = 1'b0;
        rsp_valid = 1'b0;
        check_eq("nobyp_orphan", {31'd0, orphan}, 32'd1);
        check_eq("nobyp_fail", {28'd0, fail_cnt}, 32'd1);
        rsp_one(1'b0, 8'h44);
        check_eq("nobyp_pass", {28'd0, pass_cnt}, 32'd1);

        // Responses in IDLE are ignored
        enable = 1'b0;
        step();
        step();
        check_eq("idle_busy", {31'd0, busy}, 32'd0);
        check_eq("idle_exp_ready", {31'd0, exp_ready}, 32'd0);
        rsp_one(1'b0, 8'h55);
        rsp_one(1'b1, 8'h66);
        check_eq("idle_fail", {28'd0, fail_cnt}, 32'd1);
        check_eq("idle_pass", {28'd0, pass_cnt}, 32'd1);
        check_eq("idle_ff_rsp", {23'd0, ff_rsp}, 32'h044);

        // Drain: third push coincides with enable falling
        enable = 1'b1;
        step();
        push_one(1'b0, 8'h50);
        push_one(1'b1, 8'h51);
        exp_valid  = 1'b1;
        exp_equal  = 1'b0;
        exp_result = 8'h52;
        enable     = 1'b0;
        step();
        exp_valid = 1'b0;
        check_eq("drain_exp_ready", {31'd0, exp_ready}, 32'd0);
        check_eq("drain_busy", {31'd0, busy}, 32'd1);
        rsp_one(1'b0, 8'h50);
        rsp_one(1'b1, 8'h51);
        rsp_one(1'b0, 8'h52);
        check_eq("drain_busy_last", {31'd0, busy}, 32'd1);
        check_eq("drain_done_early", {31'd0, done}, 32'd0);
        step();
        check_eq("drain_done", {31'd0, done}, 32'd1);
        check_eq("drain_busy_fall", {31'd0, busy}, 32'd0);
        check_eq("drain_pass", {28'd0, pass_cnt}, 32'd3);
        step();
        check_eq("drain_done_pulse", {31'd0, done}, 32'd0);

        // Pass counter saturation
        enable = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            push_one(1'b0, 8'(i));
            rsp_one(1'b0, 8'(i));
        end
        check_eq("sat_pass", {28'd0, pass_cnt}, 32'hF);
        check_eq("sat_fail", {28'd0, fail_cnt}, 32'd0);

        // Asynchronous reset mid-stream
        push_one(1'b0, 8'hA0);
        push_one(1'b0, 8'hA1);
        rsp_one(1'b1, 8'hA0);
        check_eq("pre_rst_err", {31'd0, err}, 32'd1);
        rstb = 1'b0;
        #2;
        check_eq("arst_pass", {28'd0, pass_cnt}, 32'd0);
        check_eq("arst_fail", {28'd0, fail_cnt}, 32'd0);
        check_eq("arst_err", {31'd0, err}, 32'd0);
        check_eq("arst_ff_exp", {23'd0, ff_exp}, 32'd0);
        check_eq("arst_busy", {31'd0, busy}, 32'd0);
        check_eq("arst_exp_ready", {31'd0, exp_ready}, 32'd0);
        #2;
        rstb = 1'b1;
        step();
        rsp_one(1'b0, 8'hA1);
        check_eq("post_rst_orphan", {31'd0, orphan}, 32'd1);
        check_eq("post_rst_ff_exp", {23'd0, ff_exp}, 32'h1FF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
